// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed display scanner with dead-time and double-buffered data
//   clk        system clock
//   rst        asynchronous active-high reset
//   enable     scan enable; low holds the scanner in DEAD, idx 0
//   load       one-cycle strobe capturing dig_in/blank_in into the pending buffer
//   dig_in     four nibbles, [3:0] is digit 0
//   blank_in   per-digit blank mask, 1 = digit dark
//   digit_val  active nibble of the current digit, to the shared segment decoders
//   an_n       registered active-low digit enables
//   upd_ack    one-cycle pulse when pending data becomes active
//   frame_tick one-cycle pulse after the last DRIVE cycle of digit 3
module seg_scan_ctrl #(
    parameter int DRIVE_CYC = 50000,
    parameter int DEAD_CYC  = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] dig_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  digit_val,
    output logic [3:0]  an_n,
    output logic        upd_ack,
    output logic        frame_tick
);
    localparam int CW = $clog2(DRIVE_CYC > DEAD_CYC ? DRIVE_CYC : DEAD_CYC);

    typedef enum logic {DEAD, DRIVE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   act_dig, act_dig_nxt, pend_dig, pend_dig_nxt;
    logic [3:0]    act_blank, act_blank_nxt, pend_blank, pend_blank_nxt, an_nxt;
    logic          pend, pend_nxt, dead_end, drive_end, frame_end, commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DEAD;
            cnt        <= '0;
            idx        <= 2'd0;
            act_dig    <= 16'h0;
            act_blank  <= 4'hF;
            pend_dig   <= 16'h0;
            pend_blank <= 4'hF;
            pend       <= 1'b0;
            an_n       <= 4'hF;
            upd_ack    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            act_dig    <= act_dig_nxt;
            act_blank  <= act_blank_nxt;
            pend_dig   <= pend_dig_nxt;
            pend_blank <= pend_blank_nxt;
            pend       <= pend_nxt;
            an_n       <= an_nxt;
            upd_ack    <= commit;
            frame_tick <= frame_end && enable;
        end
    end

    always_comb begin
        dead_end  = state == DEAD && cnt == CW'(DEAD_CYC - 1);
        drive_end = state == DRIVE && cnt == CW'(DRIVE_CYC - 1);
        frame_end = drive_end && idx == 2'd3;
        state_nxt = !enable ? DEAD : dead_end ? DRIVE : drive_end ? DEAD : state;
        cnt_nxt   = (!enable || dead_end || drive_end) ? '0 : cnt + 1'b1;
        idx_nxt   = !enable ? 2'd0 : drive_end ? idx + 2'd1 : idx;
    end

    // A load in the commit cycle bypasses the pending buffer, so pend ends up clear.
    // an_n is computed from the next state so the register lines up with the state it displays.
    always_comb begin
        commit         = pend && (frame_end || !enable);
        act_dig_nxt    = !commit ? act_dig : load ? dig_in : pend_dig;
        act_blank_nxt  = !commit ? act_blank : load ? blank_in : pend_blank;
        pend_dig_nxt   = load ? dig_in : pend_dig;
        pend_blank_nxt = load ? blank_in : pend_blank;
        pend_nxt       = !commit && (load || pend);
        an_nxt         = (state_nxt == DRIVE && !act_blank_nxt[idx_nxt]) ? ~(4'b0001 << idx_nxt) : 4'hF;
        digit_val      = act_dig[{idx, 2'b00} +: 4];
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: frame-position model check plus directed scenarios for seg_scan_ctrl
module tb_seg_scan_ctrl;
    localparam int DRV   = 4;
    localparam int DED   = 2;
    localparam int SLOT  = DRV + DED;
    localparam int FRAME = 4 * SLOT;
    localparam int LAST  = FRAME - 1;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, load = 1'b0;
    logic [15:0] dig_in = 16'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [3:0]  digit_val, an_n;
    logic        upd_ack, frame_tick;

    int tests = 0, fails = 0;

    seg_scan_ctrl #(.DRIVE_CYC(DRV), .DEAD_CYC(DED)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .dig_in(dig_in),
        .blank_in(blank_in), .digit_val(digit_val), .an_n(an_n),
        .upd_ack(upd_ack), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Model: position within the frame plus active/pending buffers, updated per edge
    int          m_pos = 0;
    logic [15:0] m_act = 16'h0, m_pdig = 16'h0;
    logic [3:0]  m_ablank = 4'hF, m_pblank = 4'hF;
    logic        m_pend = 1'b0, m_ack = 1'b0, m_tick = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos <= 0; m_act <= 16'h0; m_pdig <= 16'h0; m_ablank <= 4'hF; m_pblank <= 4'hF;
            m_pend <= 1'b0; m_ack <= 1'b0; m_tick <= 1'b0;
        end else begin
            m_tick <= enable && m_pos == LAST;
            m_ack  <= m_pend && (!enable || m_pos == LAST);
            if (m_pend && (!enable || m_pos == LAST)) begin
                m_act    <= load ? dig_in : m_pdig;
                m_ablank <= load ? blank_in : m_pblank;
                m_pend   <= 1'b0;
            end else if (load) begin
                m_pdig   <= dig_in;
                m_pblank <= blank_in;
                m_pend   <= 1'b1;
            end
            m_pos <= enable ? (m_pos == LAST ? 0 : m_pos + 1) : 0;
        end
    end

    function automatic logic [3:0] exp_an(input int pos, input logic [3:0] bl);
        int slot;
        slot = pos / SLOT;
        return (pos % SLOT < DED || bl[slot]) ? 4'hF : ~(4'b0001 << slot);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        check("model_an_n", 16'(an_n), 16'(exp_an(m_pos, m_ablank)));
        check("model_digit_val", 16'(digit_val), 16'(m_act[(m_pos / SLOT) * 4 +: 4]));
        check("model_upd_ack", 16'(upd_ack), 16'(m_ack));
        check("model_frame_tick", 16'(frame_tick), 16'(m_tick));
        check("one_anode", 16'($countones(~an_n) <= 1), 16'd1);
    end

    int cyc_n = 0, n_ack = 0, n_tick = 0, n_on = 0, last_tick = -1, gap = 0;
    initial forever begin
        @(negedge clk);
        cyc_n++;
        n_ack += int'(upd_ack);
        n_tick += int'(frame_tick);
        n_on += int'(an_n != 4'hF);
        if (frame_tick) begin
            if (last_tick >= 0) gap = cyc_n - last_tick;
            last_tick = cyc_n;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_pos(input int p);
        int k = 0;
        while (m_pos != p && k < 100) begin
            cyc(1);
            k++;
        end
        if (m_pos != p) check("wait_pos_timeout", 16'(m_pos), 16'(p));
    endtask

    task automatic pulse(input logic [15:0] d, input logic [3:0] b);
        load = 1'b1; dig_in = d; blank_in = b;
        cyc(1);
        load = 1'b0;
    endtask

    logic [3:0] seq_an [24] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7};
    int a0, t0, o0;

    initial begin
        cyc(2);
        check("rst_an_n", 16'(an_n), 16'hF);
        check("rst_digit_val", 16'(digit_val), 16'h0);
        check("rst_upd_ack", 16'(upd_ack), 16'h0);
        check("rst_frame_tick", 16'(frame_tick), 16'h0);
        // idle scan after reset: blank display, ticks every frame, no ack
        rst = 1'b0; enable = 1'b1;
        a0 = n_ack; t0 = n_tick; o0 = n_on;
        cyc(50);
        check("idle_acks", 16'(n_ack - a0), 16'd0);
        check("idle_anodes_on", 16'(n_on - o0), 16'd0);
        check("idle_ticks", 16'(n_tick - t0), 16'd2);
        check("idle_tick_gap", 16'(gap), 16'd24);
        // single load, then the full frame-2 pattern
        wait_pos(5);
        a0 = n_ack;
        pulse(16'h4321, 4'h0);
        wait_pos(LAST);
        cyc(1);
        check("commit_ack", 16'(upd_ack), 16'd1);
        check("commit_tick", 16'(frame_tick), 16'd1);
        for (int i = 0; i < FRAME; i++) begin
            check("f2_an_n", 16'(an_n), 16'(seq_an[i]));
            check("f2_digit_val", 16'(digit_val), 16'(i / SLOT + 1));
            cyc(1);
        end
        check("single_ack_count", 16'(n_ack - a0), 16'd1);
        // two loads in one frame: last wins, one ack
        a0 = n_ack;
        wait_pos(3);
        pulse(16'h1111, 4'h0);
        wait_pos(10);
        pulse(16'h00A5, 4'h0);
        wait_pos(LAST);
        cyc(1);
        wait_pos(3);
        check("dbl_an0", 16'(an_n), 16'hE);
        check("dbl_dv0", 16'(digit_val), 16'h5);
        wait_pos(9);
        check("dbl_an1", 16'(an_n), 16'hD);
        check("dbl_dv1", 16'(digit_val), 16'hA);
        wait_pos(15);
        check("dbl_dv2", 16'(digit_val), 16'h0);
        wait_pos(21);
        check("dbl_an3", 16'(an_n), 16'h7);
        wait_pos(LAST);
        cyc(1);
        check("dbl_no_second_ack", 16'(upd_ack), 16'd0);
        check("dbl_ack_count", 16'(n_ack - a0), 16'd1);
        // load in the commit cycle with data already pending: bypass
        wait_pos(4);
        pulse(16'h2222, 4'h0);
        a0 = n_ack;
        wait_pos(LAST);
        pulse(16'h9876, 4'h0);
        check("bypass_ack", 16'(upd_ack), 16'd1);
        wait_pos(3);
        check("bypass_dv0", 16'(digit_val), 16'h6);
        wait_pos(9);
        check("bypass_dv1", 16'(digit_val), 16'h7);
        wait_pos(15);
        check("bypass_dv2", 16'(digit_val), 16'h8);
        wait_pos(21);
        check("bypass_dv3", 16'(digit_val), 16'h9);
        wait_pos(LAST);
        cyc(1);
        check("bypass_pend_clear", 16'(upd_ack), 16'd0);
        check("bypass_tick", 16'(frame_tick), 16'd1);
        check("bypass_ack_count", 16'(n_ack - a0), 16'd1);
        // blank digit 3
        wait_pos(6);
        pulse(16'hABCD, 4'b1000);
        wait_pos(LAST);
        cyc(1);
        wait_pos(2);
        check("blank_an0", 16'(an_n), 16'hE);
        check("blank_dv0", 16'(digit_val), 16'hD);
        wait_pos(14);
        check("blank_an2", 16'(an_n), 16'hB);
        check("blank_dv2", 16'(digit_val), 16'hB);
        for (int i = 0; i < DRV; i++) begin
            wait_pos(20 + i);
            check("blank_an3", 16'(an_n), 16'hF);
            check("blank_dv3", 16'(digit_val), 16'hA);
        end
        // async reset during DRIVE of digit 2 with data pending
        wait_pos(13);
        pulse(16'h5555, 4'h0);
        wait_pos(15);
        check("pre_rst_an", 16'(an_n), 16'hB);
        #1 rst = 1'b1;
        #1;
        check("async_rst_an", 16'(an_n), 16'hF);
        check("async_rst_dv", 16'(digit_val), 16'h0);
        check("async_rst_ack", 16'(upd_ack), 16'h0);
        check("async_rst_tick", 16'(frame_tick), 16'h0);
        cyc(2);
        rst = 1'b0;
        a0 = n_ack; o0 = n_on;
        cyc(30);
        check("rst_discard_ack", 16'(n_ack - a0), 16'd0);
        check("rst_blank_display", 16'(n_on - o0), 16'd0);
        // enable dropped mid-frame with a load pending
        wait_pos(2);
        pulse(16'h1357, 4'h0);
        wait_pos(LAST);
        cyc(1);
        check("en_first_ack", 16'(upd_ack), 16'd1);
        wait_pos(8);
        pulse(16'h2468, 4'h0);
        check("en_pre_an", 16'(an_n), 16'hD);
        check("en_pre_dv", 16'(digit_val), 16'h5);
        enable = 1'b0;
        cyc(1);
        check("en_off_an", 16'(an_n), 16'hF);
        check("en_off_ack", 16'(upd_ack), 16'd1);
        check("en_off_dv", 16'(digit_val), 16'h8);
        cyc(1);
        check("en_off_ack_done", 16'(upd_ack), 16'd0);
        pulse(16'h1111, 4'h0);
        check("en_off_capture", 16'(upd_ack), 16'd0);
        cyc(1);
        check("en_off_commit_ack", 16'(upd_ack), 16'd1);
        check("en_off_commit_dv", 16'(digit_val), 16'h1);
        t0 = n_tick; o0 = n_on;
        cyc(30);
        check("en_off_no_tick", 16'(n_tick - t0), 16'd0);
        check("en_off_dark", 16'(n_on - o0), 16'd0);
        enable = 1'b1;
        cyc(2);
        check("en_restart_an", 16'(an_n), 16'hE);
        check("en_restart_dv", 16'(digit_val), 16'h1);
        cyc(30);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter: DRIVE_CYC, default 50000, clock cycles each digit is driven (SHALL be >= 2).
REQ-002 Parameter: DEAD_CYC, default 500, all-off anti-ghosting cycles before each digit (SHALL be >= 1).
REQ-003 Ports, in order:
- clk  in  1  system clock; the block SHALL use one clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  scan enable.
- load  in  1  one-cycle strobe that captures dig_in and blank_in.
- dig_in  in  16  four BCD/hex digits; [3:0] is digit 0, [15:12] is digit 3.
- blank_in  in  4  per-digit blank mask; 1 = digit dark.
- digit_val  out  4  nibble to the shared segment decoders.
- an_n  out  4  active-low digit enables; bit i = digit i.
- upd_ack  out  1  one-cycle pulse when new data becomes active.
- frame_tick  out  1  one-cycle pulse at the end of each scan frame.

Function
REQ-004 FSM states SHALL be exactly two: DEAD and DRIVE. A cycle counter cnt and a 2-bit digit index idx SHALL be kept.
REQ-005 In DEAD:
- an_n SHALL be 4'hF.
- cnt SHALL count 0..DEAD_CYC-1.
- At DEAD_CYC-1 the FSM SHALL go to DRIVE with cnt=0.
REQ-006 In DRIVE:
- an_n SHALL be ~(1<<idx), or 4'hF when active blank bit idx is 1.
- cnt SHALL count 0..DRIVE_CYC-1.
- At DRIVE_CYC-1 the FSM SHALL go to DEAD with cnt=0, and idx SHALL advance modulo 4 (3 wraps to 0).
REQ-007 digit_val SHALL equal active nibble idx in both states. During DEAD it therefore shows the upcoming digit, so the decoders settle before the anode turns on.
REQ-008 A frame SHALL be 4*(DEAD_CYC+DRIVE_CYC) cycles. frame_tick SHALL be registered and high for exactly the one cycle after the final DRIVE cycle of idx 3.
REQ-009 Shadow registers (double buffering):
- load=1 SHALL copy dig_in/blank_in into pending registers and set pend.
- A later load before commit SHALL overwrite the pending data (last load wins).
REQ-010 Commit SHALL happen on the final DRIVE cycle of idx 3 when pend=1:
- active registers take the pending data;
- pend clears;
- upd_ack SHALL pulse in the next cycle, the same cycle frame_tick pulses.
REQ-011 If load coincides with the commit cycle, the block SHALL commit the dig_in/blank_in presented in that cycle (bypass), with one upd_ack.
REQ-012 If a new load arrives in the cycle of a commit, no pending data SHALL remain after it; pend SHALL be 0.
REQ-013 While enable=0:
- the FSM SHALL be held in DEAD with cnt=0 and idx=0, and an_n SHALL be 4'hF;
- loads SHALL still be captured;
- any pending data SHALL commit on the next clock edge, with upd_ack in the following cycle;
- frame_tick SHALL stay 0.
REQ-014 Deasserting enable mid-frame SHALL take effect on the next edge. Reasserting it SHALL restart at DEAD, idx 0, cnt 0.
REQ-015 an_n SHALL be a registered output, so it is glitch-free.
REQ-016 At no time SHALL more than one an_n bit be low.

Reset
REQ-017 rst=1 SHALL immediately (asynchronously) force:
- state DEAD, cnt 0, idx 0;
- an_n 4'hF, digit_val 0;
- active and pending digits 0, active and pending blank 4'hF;
- pend 0, upd_ack 0, frame_tick 0.
REQ-018 After rst falls with enable=1, scanning SHALL begin at DEAD idx 0 on the first clock edge, with the display fully blank until the first commit.
REQ-019 Reset asserted mid-DRIVE SHALL turn all anodes off without waiting for a clock edge, and SHALL discard pending data.

Verification
All scenarios use DRIVE_CYC=4 and DEAD_CYC=2, giving a 24-cycle frame.
REQ-020 Reset release, enable=1, no load -> an_n stays 4'hF; frame_tick pulses every 24 cycles; upd_ack is never asserted.
REQ-021 load with dig_in=16'h4321 and blank_in=0 in frame 1 -> upd_ack and frame_tick pulse together at the end of frame 1. Frame 2 then shows:
- an_n sequence F(2 cycles), E(4), F(2), D(4), F(2), B(4), F(2), 7(4);
- digit_val 1, 2, 3, 4 in the matching slots.
REQ-022 Two loads in one frame, 16'h1111 then 16'h00A5 -> only 16'h00A5 is displayed; exactly one upd_ack is issued.
REQ-023 load=1 with 16'h9876 exactly in the commit cycle -> the next frame shows 9876; one upd_ack; pend=0 afterwards.
REQ-024 Active blank 4'b1000 -> an_n stays 4'hF for all 4 DRIVE cycles of digit 3; the other digits are unaffected.
REQ-025 Mid-frame stimulus:
- rst pulsed during DRIVE of digit 2 -> an_n reads 4'hF before the next edge and all outputs reach their reset values;
- enable dropped mid-frame with a load pending -> an_n is 4'hF at the next edge and upd_ack follows one cycle later.
